// File: rtl/fpu_tile_host.sv
// Host-side sequencer for the FPU add/sub tile: loads operands, pulses the tile
// enable, waits a fixed latency or the tile's early strobe, then returns the result.
module fpu_tile_host #(
  parameter int REG_WIDTH     = 32,
  parameter int CSR_IN_WIDTH  = 16,
  parameter int CSR_OUT_WIDTH = 16,
  parameter int LATENCY       = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_op,
  input  logic [REG_WIDTH-1:0]     cmd_a,
  input  logic [REG_WIDTH-1:0]     cmd_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [REG_WIDTH-1:0]     rsp_data,
  output logic [CSR_OUT_WIDTH-1:0] rsp_csr,
  output logic                     rsp_early,
  output logic [15:0]              done_count,
  output logic [CSR_IN_WIDTH-1:0]  csr_in,
  output logic [REG_WIDTH-1:0]     data_reg_a,
  output logic [REG_WIDTH-1:0]     data_reg_b,
  input  logic [REG_WIDTH-1:0]     data_reg_c,
  input  logic [CSR_OUT_WIDTH-1:0] csr_out,
  input  logic                     csr_in_re,
  input  logic                     csr_out_we
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t                   state_reg;
  logic                     cmd_ready_reg;
  logic [REG_WIDTH-1:0]     a_reg;
  logic [REG_WIDTH-1:0]     b_reg;
  logic                     op_reg;
  logic                     en_reg;
  logic [7:0]               cnt_reg;
  logic                     rsp_valid_reg;
  logic [REG_WIDTH-1:0]     rsp_data_reg;
  logic [CSR_OUT_WIDTH-1:0] rsp_csr_reg;
  logic                     rsp_early_reg;
  logic [15:0]              done_count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      cmd_ready_reg  <= 1'b1;
      a_reg          <= '0;
      b_reg          <= '0;
      op_reg         <= 1'b0;
      en_reg         <= 1'b0;
      cnt_reg        <= 8'd0;
      rsp_valid_reg  <= 1'b0;
      rsp_data_reg   <= '0;
      rsp_csr_reg    <= '0;
      rsp_early_reg  <= 1'b0;
      done_count_reg <= 16'd0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (cmd_valid) begin
            a_reg         <= cmd_a;
            b_reg         <= cmd_b;
            op_reg        <= cmd_op;
            cmd_ready_reg <= 1'b0;
            state_reg     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          en_reg    <= 1'b1;
          state_reg <= ST_ISSUE;
        end
        ST_ISSUE: begin
          cnt_reg   <= 8'(LATENCY - 1);
          state_reg <= ST_WAIT;
          if (csr_in_re) en_reg <= 1'b0;
        end
        ST_WAIT: begin
          // The tile acknowledging csr_in only drops the enable; timing is unaffected.
          if (csr_in_re) en_reg <= 1'b0;
          cnt_reg <= cnt_reg - 8'd1;
          if (csr_out_we || cnt_reg == 8'd0) begin
            rsp_data_reg   <= data_reg_c;
            rsp_csr_reg    <= csr_out;
            rsp_early_reg  <= csr_out_we;
            rsp_valid_reg  <= 1'b1;
            en_reg         <= 1'b0;
            done_count_reg <= done_count_reg + 16'd1;
            state_reg      <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            cmd_ready_reg <= 1'b1;
            state_reg     <= ST_IDLE;
          end
        end
        default: begin
          state_reg     <= ST_IDLE;
          cmd_ready_reg <= 1'b1;
          en_reg        <= 1'b0;
          rsp_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  // Only the enable (bit 15) and op-select (bit 4) CSR bits are ever driven.
  genvar gi;
  generate
    for (gi = 0; gi < CSR_IN_WIDTH; gi++) begin : g_csr_in
      if (gi == 15) begin : g_en
        assign csr_in[gi] = en_reg;
      end else if (gi == 4) begin : g_op
        assign csr_in[gi] = op_reg;
      end else begin : g_zero
        assign csr_in[gi] = 1'b0;
      end
    end
  endgenerate

  assign cmd_ready  = cmd_ready_reg;
  assign rsp_valid  = rsp_valid_reg;
  assign rsp_data   = rsp_data_reg;
  assign rsp_csr    = rsp_csr_reg;
  assign rsp_early  = rsp_early_reg;
  assign done_count = done_count_reg;
  assign data_reg_a = a_reg;
  assign data_reg_b = b_reg;

endmodule

// File: tb/tb_fpu_tile_host.sv
// Self-checking bench for fpu_tile_host: vector table plus hand sequences for
// early strobe, backpressure, csr_in_re and reset; responses checked via scoreboard.
module tb_fpu_tile_host;
  localparam int LAT  = 2;
  localparam int LAT8 = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main instance (LATENCY=2)
  logic        cmd_valid, cmd_ready, cmd_op;
  logic [31:0] cmd_a, cmd_b;
  logic        rsp_valid, rsp_ready, rsp_early;
  logic [31:0] rsp_data;
  logic [15:0] rsp_csr, done_count, csr_in;
  logic [31:0] data_reg_a, data_reg_b, data_reg_c;
  logic [15:0] csr_out;
  logic        csr_in_re, csr_out_we;

  // Second instance (LATENCY=8) for the early-strobe case
  logic        e_cmd_valid, e_cmd_ready, e_cmd_op;
  logic [31:0] e_cmd_a, e_cmd_b;
  logic        e_rsp_valid, e_rsp_ready, e_rsp_early;
  logic [31:0] e_rsp_data;
  logic [15:0] e_rsp_csr, e_done_count, e_csr_in;
  logic [31:0] e_data_reg_a, e_data_reg_b, e_data_reg_c;
  logic [15:0] e_csr_out;
  logic        e_csr_in_re, e_csr_out_we;

  fpu_tile_host #(.REG_WIDTH(32), .CSR_IN_WIDTH(16), .CSR_OUT_WIDTH(16), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_csr(rsp_csr),
    .rsp_early(rsp_early), .done_count(done_count), .csr_in(csr_in),
    .data_reg_a(data_reg_a), .data_reg_b(data_reg_b), .data_reg_c(data_reg_c),
    .csr_out(csr_out), .csr_in_re(csr_in_re), .csr_out_we(csr_out_we)
  );

  fpu_tile_host #(.REG_WIDTH(32), .CSR_IN_WIDTH(16), .CSR_OUT_WIDTH(16), .LATENCY(LAT8)) dut8 (
    .clk(clk), .rst(rst),
    .cmd_valid(e_cmd_valid), .cmd_ready(e_cmd_ready), .cmd_op(e_cmd_op), .cmd_a(e_cmd_a), .cmd_b(e_cmd_b),
    .rsp_valid(e_rsp_valid), .rsp_ready(e_rsp_ready), .rsp_data(e_rsp_data), .rsp_csr(e_rsp_csr),
    .rsp_early(e_rsp_early), .done_count(e_done_count), .csr_in(e_csr_in),
    .data_reg_a(e_data_reg_a), .data_reg_b(e_data_reg_b), .data_reg_c(e_data_reg_c),
    .csr_out(e_csr_out), .csr_in_re(e_csr_in_re), .csr_out_we(e_csr_out_we)
  );

  // Tile model: result is only valid in the cycle LAT+1 after accept, garbage otherwise,
  // so a capture on the wrong edge is visible.
  logic [7:0]  tile_cnt;
  logic [31:0] tile_result;
  logic [15:0] tile_csr;
  always_ff @(posedge clk) begin
    if (rst) tile_cnt <= 8'd0;
    else if (cmd_valid && cmd_ready) tile_cnt <= 8'd0;
    else if (tile_cnt != 8'hFF) tile_cnt <= tile_cnt + 8'd1;
  end
  assign data_reg_c = (tile_cnt == 8'(LAT + 1)) ? tile_result : 32'hDEADBEEF;
  assign csr_out    = (tile_cnt == 8'(LAT + 1)) ? tile_csr : 16'hFFFF;

  typedef struct packed {
    logic [31:0] data;
    logic [15:0] csr;
    logic        early;
  } rsp_t;
  rsp_t sb[$];
  rsp_t last_exp;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [15:0] busy;
  } vec_t;
  vec_t vecs[4];

  int total = 0;
  int bad = 0;
  int exp_done = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic early);
    chk("idle_ready", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    tile_result = c; tile_csr = 16'h0001;
    sb.push_back(rsp_t'{data: c, csr: 16'h0001, early: early});
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("load_csr", 64'(csr_in), 64'({11'b0, op, 4'b0}));
    chk("load_a", 64'(data_reg_a), 64'(a));
    chk("load_b", 64'(data_reg_b), 64'(b));
    chk("load_ready", 64'(cmd_ready), 64'd0);
  endtask

  // Starts at the LOAD-cycle negedge (cycle 1 after accept).
  task automatic wait_rsp(input logic [15:0] busy, input int early_n, input logic re_test);
    int n;
    n = 1;
    while (n < 30) begin
      @(negedge clk);
      n++;
      csr_out_we = 1'b0;
      csr_in_re  = 1'b0;
      if (rsp_valid) break;
      chk("busy_ready", 64'(cmd_ready), 64'd0);
      chk("busy_csr", 64'(csr_in), 64'((re_test && n > 2) ? (busy & 16'h7FFF) : busy));
      csr_out_we = (n == early_n);
      csr_in_re  = re_test && (n == 2);
    end
    csr_out_we = 1'b0;
    csr_in_re  = 1'b0;
    chk("rsp_latency", 64'(n), 64'(LAT + 3));
    chk("rsp_valid", 64'(rsp_valid), 64'd1);
    if (sb.size() > 0) last_exp = sb.pop_front();
    exp_done++;
    chk("rsp_data", 64'(rsp_data), 64'(last_exp.data));
    chk("rsp_csr", 64'(rsp_csr), 64'(last_exp.csr));
    chk("rsp_early", 64'(rsp_early), 64'(last_exp.early));
    chk("done_count", 64'(done_count), 64'(16'(exp_done)));
    chk("done_csr", 64'(csr_in), 64'(busy & 16'h7FFF));
    $display("txn: a=%08h b=%08h op=%0d -> data=%08h csr=%04h early=%0d count=%0d",
             data_reg_a, data_reg_b, busy[4], rsp_data, rsp_csr, rsp_early, done_count);
  endtask

  task automatic consume(input int hold);
    rsp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(rsp_valid), 64'd1);
      chk("hold_data", 64'(rsp_data), 64'(last_exp.data));
      chk("hold_csr", 64'(rsp_csr), 64'(last_exp.csr));
      chk("hold_en", 64'(csr_in[15]), 64'd0);
      chk("hold_ready", 64'(cmd_ready), 64'd0);
      chk("hold_count", 64'(done_count), 64'(16'(exp_done)));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("drain_valid", 64'(rsp_valid), 64'd0);
    chk("drain_ready", 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n8;
    rst = 1'b1;
    cmd_valid = 0; cmd_op = 0; cmd_a = 0; cmd_b = 0; rsp_ready = 0;
    csr_in_re = 0; csr_out_we = 0; tile_result = 0; tile_csr = 0;
    e_cmd_valid = 0; e_cmd_op = 0; e_cmd_a = 0; e_cmd_b = 0; e_rsp_ready = 0;
    e_csr_in_re = 0; e_csr_out_we = 0; e_csr_out = 0; e_data_reg_c = 0;

    vecs[0] = '{op: 1'b0, a: 32'h3F800000, b: 32'h40000000, c: 32'h40400000, busy: 16'h8000};
    vecs[1] = '{op: 1'b1, a: 32'h40A00000, b: 32'h40400000, c: 32'h40000000, busy: 16'h8010};
    vecs[2] = '{op: 1'b0, a: 32'h3F800000, b: 32'hBF800000, c: 32'h00000000, busy: 16'h8000};
    vecs[3] = '{op: 1'b1, a: 32'hC0000000, b: 32'h3F800000, c: 32'hC0400000, busy: 16'h8010};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    chk("rst_csr", 64'(csr_in), 64'd0);
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_count", 64'(done_count), 64'd0);
    chk("rst_data", 64'(rsp_data), 64'd0);
    chk("rst_a", 64'(data_reg_a), 64'd0);

    for (int i = 0; i < 4; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c, 1'b0);
      wait_rsp(vecs[i].busy, 0, 1'b0);
      consume(0);
      chk("persist_a", 64'(data_reg_a), 64'(vecs[i].a));
      chk("persist_csr", 64'(csr_in), 64'(vecs[i].busy & 16'h7FFF));
    end

    // Early strobe coinciding with latency expiry still reports early.
    issue(1'b0, 32'h11111111, 32'h22222222, 32'h33333333, 1'b1);
    wait_rsp(16'h8000, LAT + 2, 1'b0);
    consume(0);

    // csr_in_re in ISSUE drops the enable but not the schedule.
    issue(1'b1, 32'h44444444, 32'h55555555, 32'h66666666, 1'b0);
    wait_rsp(16'h8010, 0, 1'b1);
    consume(0);

    // Backpressure with a second command waiting.
    issue(1'b0, 32'h01020304, 32'h05060708, 32'h0A0B0C0D, 1'b0);
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_a = 32'h7F000000; cmd_b = 32'h00000001;
    wait_rsp(16'h8000, 0, 1'b0);
    consume(10);
    issue(1'b1, 32'h7F000000, 32'h00000001, 32'h7EFFFFFF, 1'b0);
    wait_rsp(16'h8010, 0, 1'b0);
    consume(0);

    // LATENCY=8 instance: early strobe in 2nd WAIT cycle, then plain expiry.
    for (int k = 0; k < 2; k++) begin
      chk("e_idle_ready", 64'(e_cmd_ready), 64'd1);
      e_cmd_valid = 1'b1; e_cmd_op = 1'b0; e_cmd_a = 32'h3F800000; e_cmd_b = 32'h3F800000;
      e_data_reg_c = (k == 0) ? 32'h12345678 : 32'hCAFEF00D;
      e_csr_out = (k == 0) ? 16'h0000 : 16'h0042;
      @(negedge clk);
      e_cmd_valid = 1'b0;
      n8 = 1;
      while (n8 < 30) begin
        @(negedge clk);
        n8++;
        e_csr_out_we = 1'b0;
        if (k == 0) e_csr_out = 16'h0000;
        if (e_rsp_valid) break;
        if (k == 0 && n8 == 4) begin
          e_csr_out_we = 1'b1;
          e_csr_out = 16'h00A5;
        end
      end
      e_csr_out_we = 1'b0;
      chk("e_latency", 64'(n8), 64'((k == 0) ? 5 : LAT8 + 3));
      chk("e_rsp_valid", 64'(e_rsp_valid), 64'd1);
      chk("e_rsp_csr", 64'(e_rsp_csr), 64'((k == 0) ? 16'h00A5 : 16'h0042));
      chk("e_rsp_data", 64'(e_rsp_data), 64'((k == 0) ? 32'h12345678 : 32'hCAFEF00D));
      chk("e_rsp_early", 64'(e_rsp_early), 64'((k == 0) ? 1 : 0));
      chk("e_done_count", 64'(e_done_count), 64'(k + 1));
      $display("txn8: data=%08h csr=%04h early=%0d cycles=%0d", e_rsp_data, e_rsp_csr, e_rsp_early, n8);
      e_rsp_ready = 1'b1;
      @(negedge clk);
      e_rsp_ready = 1'b0;
      chk("e_drain_valid", 64'(e_rsp_valid), 64'd0);
    end

    // Reset mid-WAIT discards the in-flight result.
    issue(1'b1, 32'h0BADF00D, 32'h00C0FFEE, 32'h12121212, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_en", 64'(csr_in), 64'h8010);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    exp_done = 0;
    chk("mid_rst_csr", 64'(csr_in), 64'd0);
    chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_count", 64'(done_count), 64'd0);
    chk("mid_rst_ready", 64'(cmd_ready), 64'd1);
    $display("txn: reset during WAIT");

    issue(1'b0, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0);
    wait_rsp(16'h8000, 0, 1'b0);
    consume(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fpu_tile_host.md
# fpu_tile_host

Host-side sequencer for the FPU add/sub IP tile's CSR/data-register interface. It accepts one operation at a time on a valid/ready command port, loads the tile's operand registers, raises the tile enable and operation-select CSR bits, and waits a fixed result latency or the tile's early-completion strobe. It then captures the tile result and CSR readback and presents them on a valid/ready response port. It sits between the SoC-side command source and the tile, driving the tile's inputs and consuming its outputs.

## Interface
- REG_WIDTH, 32, operand/result width
- CSR_IN_WIDTH, 16, tile CSR-in width; must be ≥ 16
- CSR_OUT_WIDTH, 16, tile CSR-out width
- LATENCY, 2, WAIT cycles before capture; legal range 1..255
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  host idle, command accepted when cmd_valid & cmd_ready
- cmd_op  in  1  0 = add, 1 = subtract
- cmd_a, cmd_b  in  REG_WIDTH  operands
- rsp_valid  out  1  result held
- rsp_ready  in  1  consumer takes result
- rsp_data  out  REG_WIDTH  captured data_reg_c
- rsp_csr  out  CSR_OUT_WIDTH  captured csr_out
- rsp_early  out  1  capture caused by csr_out_we, not latency expiry
- done_count  out  16  completed operations, wraps 0xFFFF→0x0000
- csr_in  out  CSR_IN_WIDTH  to tile: bit 15 = enable, bit 4 = op select, all other bits 0
- data_reg_a, data_reg_b  out  REG_WIDTH  to tile operands
- data_reg_c  in  REG_WIDTH  tile result
- csr_out  in  CSR_OUT_WIDTH  tile CSR readback
- csr_in_re  in  1  tile consumed csr_in
- csr_out_we  in  1  tile result valid strobe

## Operation
- Reset: state IDLE; all outputs 0; `cmd_ready` = 1 from the first cycle after reset.
- IDLE
  - `cmd_ready` = 1.
  - On accept: register `cmd_a` → `data_reg_a`, `cmd_b` → `data_reg_b`, `cmd_op` → `csr_in[4]`; keep `csr_in[15]` = 0; go to LOAD.
- LOAD
  - One cycle with operands stable and enable low.
  - Go to ISSUE.
- ISSUE
  - `csr_in[15]` = 1.
  - Load counter with LATENCY-1.
  - Go to WAIT.
- WAIT
  - `csr_in[15]` stays 1 and the counter decrements each cycle.
  - If `csr_out_we` = 1: capture `data_reg_c`/`csr_out` into `rsp_data`/`rsp_csr`, set `rsp_early` = 1, go to DONE.
  - Else if counter = 0: capture the same registers, set `rsp_early` = 0, go to DONE.
  - If `csr_out_we` and counter expiry coincide, `rsp_early` = 1.
- DONE
  - `csr_in[15]` = 0; `rsp_valid` = 1; `rsp_data`, `rsp_csr`, `rsp_early` held stable.
  - `done_count` increments once, on DONE entry.
  - On `rsp_ready` = 1: `rsp_valid` drops, go to IDLE.
- csr_in_re
  - High in ISSUE or WAIT: `csr_in[15]` drops to 0 from the next cycle.
  - The counter and state continue unchanged.
  - Ignored in other states.
- Operand persistence: `data_reg_a`, `data_reg_b` and `csr_in[4]` hold their last values until the next accepted command.
- No arithmetic is performed by this block; captured results pass through unmodified.

## Timing
- Command accepted at edge E:
  - LOAD cycle: E+1.
  - `csr_in[15]` first high in cycle E+2 (ISSUE).
  - WAIT occupies cycles E+3 … E+2+LATENCY.
  - Capture happens at the edge closing the last WAIT cycle.
  - `rsp_valid` = 1 from cycle E+3+LATENCY.
- Latency: command accept to `rsp_valid` is LATENCY+3 cycles when no early strobe occurs.
- Throughput: one operation per LATENCY+4 cycles minimum (response consumed in its first cycle, IDLE re-entered next cycle).
- `cmd_ready` is 0 from LOAD through DONE, so no command is accepted while busy.
- `rsp_valid` held with `rsp_ready` low: state and all response fields stay frozen indefinitely.
- `rst` asserted in any state: next edge returns to IDLE with every output at its reset value, including `done_count` = 0 and `csr_in` = 0. An in-flight result is discarded.

## Test plan
- Add, LATENCY=2, tile model returns the sum after 2 cycles:
  - Stimulus: `cmd_a` = 0x3F800000, `cmd_b` = 0x40000000, `cmd_op` = 0.
  - Required: `csr_in` = 0x8000 in ISSUE/WAIT; `rsp_valid` 5 cycles after accept; `rsp_data` = 0x40400000; `rsp_early` = 0; `done_count` = 1.
- Subtract:
  - Stimulus: `cmd_a` = 0x40A00000, `cmd_b` = 0x40400000, `cmd_op` = 1.
  - Required: `csr_in` = 0x8010 in ISSUE/WAIT, 0x0010 in DONE; `rsp_data` = 0x40000000.
- Early strobe, LATENCY=8:
  - Stimulus: `csr_out_we` pulsed in the 2nd WAIT cycle with `csr_out` = 0x00A5.
  - Required: `rsp_valid` next cycle; `rsp_csr` = 0x00A5; `rsp_early` = 1.
- Backpressure:
  - Stimulus: hold `rsp_ready` = 0 for 10 cycles while `cmd_valid` = 1.
  - Required: `cmd_ready` = 0 throughout, response fields stable, no second enable pulse; after `rsp_ready` the second command is accepted in IDLE.
- `csr_in_re`:
  - Stimulus: `csr_in_re` = 1 in ISSUE.
  - Required: `csr_in[15]` = 0 from the first WAIT cycle; `rsp_valid` still at accept + LATENCY+3.
- Reset mid-WAIT:
  - Stimulus: assert `rst` one cycle in WAIT.
  - Required: next cycle `csr_in` = 0, `rsp_valid` = 0, `done_count` = 0, `cmd_ready` = 1.
